// File: rtl/matrix_select_pipe.sv
// Selects one of NUM_SRC square matrices and applies pass/transpose/symmetrize/negate.
// The result sits in a single output register behind a valid/ready handshake.
module matrix_select_pipe #(
    parameter int DATA_W  = 26,
    parameter int DIM     = 4,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                            clk_msel,
    input  logic                            rstn_msel,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SEL_W-1:0]                sel,
    input  logic [1:0]                      mode,
    input  logic [NUM_SRC*DIM*DIM*DATA_W-1:0] in_mat,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DIM*DIM*DATA_W-1:0]       out_mat,
    output logic                            sel_err,
    output logic [15:0]                     xfer_cnt
);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_TRAN = 2'b01;
    localparam logic [1:0] MODE_SYM  = 2'b10;

    // Average of a symmetric pair: widen by one bit so the sum cannot wrap, then floor-halve.
    function automatic logic signed [DATA_W-1:0] sym_avg(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        logic signed [DATA_W:0] sum;
        sum = {x[DATA_W-1], x} + {y[DATA_W-1], y};
        return sum[DATA_W:1];
    endfunction

    // Two's-complement negate that wraps; the most-negative value maps to itself.
    function automatic logic signed [DATA_W-1:0] neg_wrap(
        input logic signed [DATA_W-1:0] x
    );
        return ~x + 1'b1;
    endfunction

    logic                        sel_oob_p0;
    logic signed [DATA_W-1:0]    a_p0   [DIM][DIM];
    logic [DIM*DIM*DATA_W-1:0]   res_p0;
    logic [DIM*DIM*DATA_W-1:0]   mat_p1;
    logic                        vld_p1;
    logic                        in_xfer;
    logic                        out_xfer;

    assign sel_oob_p0 = (32'(sel) >= NUM_SRC);
    assign in_ready   = !vld_p1 || out_ready;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = vld_p1 && out_ready;
    assign out_valid  = vld_p1;
    assign out_mat    = mat_p1;

    // Stage p0: source select and element-wise operation
    always_comb begin
        int src;
        logic signed [DATA_W-1:0] elem;
        src    = sel_oob_p0 ? 0 : int'(sel);
        res_p0 = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                a_p0[r][c] = in_mat[((src*DIM+r)*DIM+c)*DATA_W +: DATA_W];
            end
        end
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                case (mode)
                    MODE_PASS: elem = a_p0[r][c];
                    MODE_TRAN: elem = a_p0[c][r];
                    MODE_SYM:  elem = sym_avg(a_p0[r][c], a_p0[c][r]);
                    default:   elem = neg_wrap(a_p0[r][c]);
                endcase
                res_p0[(r*DIM+c)*DATA_W +: DATA_W] = elem;
            end
        end
    end

    // Stage p1: output register, handshake state and status
    always_ff @(posedge clk_msel or negedge rstn_msel) begin
        if (!rstn_msel) begin
            vld_p1   <= 1'b0;
            mat_p1   <= '0;
            sel_err  <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (in_xfer) begin
                mat_p1 <= res_p0;
                vld_p1 <= 1'b1;
                if (sel_oob_p0)
                    sel_err <= 1'b1;
            end else if (out_xfer) begin
                vld_p1 <= 1'b0;
            end
            if (out_xfer)
                xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_matrix_select_pipe.sv
// Directed bench for matrix_select_pipe (DATA_W=26, DIM=4, NUM_SRC=3).
module tb_matrix_select_pipe;

    localparam int DATA_W  = 26;
    localparam int DIM     = 4;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;

    logic                              clk_msel = 1'b0;
    logic                              rstn_msel;
    logic                              in_valid;
    logic                              in_ready;
    logic [SEL_W-1:0]                  sel;
    logic [1:0]                        mode;
    logic [NUM_SRC*DIM*DIM*DATA_W-1:0] in_mat;
    logic                              out_valid;
    logic                              out_ready;
    logic [DIM*DIM*DATA_W-1:0]         out_mat;
    logic                              sel_err;
    logic [15:0]                       xfer_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    matrix_select_pipe #(
        .DATA_W(DATA_W), .DIM(DIM), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)
    ) dut (
        .clk_msel(clk_msel), .rstn_msel(rstn_msel),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .in_mat(in_mat),
        .out_valid(out_valid), .out_ready(out_ready), .out_mat(out_mat),
        .sel_err(sel_err), .xfer_cnt(xfer_cnt)
    );

    always #5 clk_msel = ~clk_msel;

    task automatic step();
        @(posedge clk_msel);
        #1;
    endtask

    task automatic set_elem(input int s, input int r, input int c, input int v);
        in_mat[((s*DIM+r)*DIM+c)*DATA_W +: DATA_W] = v[DATA_W-1:0];
    endtask

    function automatic logic signed [DATA_W-1:0] get_out(input int r, input int c);
        return out_mat[(r*DIM+c)*DATA_W +: DATA_W];
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rstn_msel = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = '0;
        mode      = 2'b00;
        in_mat    = '0;
        for (int s = 0; s < NUM_SRC; s++)
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++)
                    set_elem(s, r, c, ((s == 1) ? 0 : (s == 0) ? 100 : 200) + r*4 + c);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_mat_nz", {31'b0, |out_mat}, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        rstn_msel = 1'b1;
        step();

        // Pass, sel=1
        sel = 2'd1; mode = 2'b00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("pass_valid", out_valid, 1);
        check("pass_23", get_out(2, 3), 11);
        check("pass_00", get_out(0, 0), 0);
        step();
        check("pass_valid_drop", out_valid, 0);
        check("pass_cnt", xfer_cnt, 1);
        check("pass_retain", get_out(2, 3), 11);

        // Transpose
        mode = 2'b01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("tran_23", get_out(2, 3), 14);
        check("tran_32", get_out(3, 2), 11);
        check("tran_11", get_out(1, 1), 5);
        step();
        check("tran_cnt", xfer_cnt, 2);

        // Symmetrize
        set_elem(1, 0, 1, 5);         set_elem(1, 1, 0, -2);
        set_elem(1, 2, 3, -3);        set_elem(1, 3, 2, 0);
        set_elem(1, 1, 2, 33554431);  set_elem(1, 2, 1, 33554431);
        mode = 2'b10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("sym_01", get_out(0, 1), 1);
        check("sym_10", get_out(1, 0), 1);
        check("sym_23_floor", get_out(2, 3), -2);
        check("sym_32_floor", get_out(3, 2), -2);
        check("sym_12_max", get_out(1, 2), 33554431);
        check("sym_02", get_out(0, 2), 5);
        check("sym_diag", get_out(3, 3), 15);
        step();
        check("sym_cnt", xfer_cnt, 3);

        // Negate
        set_elem(1, 0, 0, -33554432); set_elem(1, 1, 1, 7);
        mode = 2'b11; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("neg_min", get_out(0, 0), -33554432);
        check("neg_11", get_out(1, 1), -7);
        check("neg_01", get_out(0, 1), -5);
        step();
        check("neg_cnt", xfer_cnt, 4);

        // Back-pressure
        mode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
        step();
        check("bp_accept_valid", out_valid, 1);
        check("bp_accept_11", get_out(1, 1), 7);
        set_elem(1, 1, 1, 99); mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_11", get_out(1, 1), 7);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", in_ready, 1);
        step();
        check("bp_reload_valid", out_valid, 1);
        check("bp_reload_11", get_out(1, 1), -99);
        check("bp_cnt", xfer_cnt, 5);
        in_valid = 1'b0;
        step();
        check("bp_drain_valid", out_valid, 0);
        check("bp_drain_cnt", xfer_cnt, 6);

        // Streaming until the counter wraps
        in_valid = 1'b1;
        step();
        check("stream_valid", out_valid, 1);
        for (int i = 0; i < 65529; i++) step();
        check("stream_valid_kept", out_valid, 1);
        check("cnt_ffff", xfer_cnt, 65535);
        check("sel_err_clear", sel_err, 0);

        // Out-of-range select falls back to source 0
        sel = 2'd3; mode = 2'b00;
        step();
        check("cnt_wrap", xfer_cnt, 0);
        check("oob_00", get_out(0, 0), 100);
        check("oob_33", get_out(3, 3), 115);
        check("oob_sel_err", sel_err, 1);
        sel = 2'd0;
        step();
        check("oob_sticky", sel_err, 1);
        out_ready = 1'b0;
        step();
        check("pending_valid", out_valid, 1);

        // Asynchronous reset with a pending result
        #2;
        rstn_msel = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_sel_err", sel_err, 0);
        check("arst_mat_nz", {31'b0, |out_mat}, 0);
        check("arst_cnt", xfer_cnt, 0);
        #1;
        rstn_msel = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        sel = 2'd2; mode = 2'b00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_first_valid", out_valid, 1);
        check("post_rst_src2_23", get_out(2, 3), 211);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
